// File: rtl/reg_wb_stage.sv
// reg_wb_stage -- write-back stage of the pipeline.
// Holds one retiring instruction and drives the register-file write port.
// A non-load retires one cycle after it is accepted. A load retires once its
// data is back; the stage stalls (mem_ready = 0) until ld_valid arrives.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_valid/ready   handshake with the memory-access stage
//   mem_ir            instruction slice {Rc[14:10], Ra[9:5], Rb[4:0]}
//   mem_wr_en         instruction writes Rc
//   mem_is_load       instruction is LD/LDR
//   mem_result        ALU result / PC+4 for non-loads
//   ld_valid, ld_data load data returned from data memory
//   we, wa, wd        register-file write port (wa[5] is always 0)
//   ir_wb             held instruction (7FFF when the stage is empty)
//   opcode_ld_ldr_wb  held instruction is a load
//   wb_bypass         bypass value, equal to wd
//   wb_stall          waiting on load data
//   ld_err            sticky flag: ld_valid seen with no load to receive it
//   retire_cnt        WRITE-cycle counter
//   ld_wait_cnt       WAIT_LD-cycle counter
//
// Configuration macro: WB_PERF_CNT_EN enables the two performance counters;
// when it is undefined both counters read 0 and the ports stay in place.
module reg_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [14:0] mem_ir,
  input  logic        mem_wr_en,
  input  logic        mem_is_load,
  input  logic [31:0] mem_result,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        we,
  output logic [5:0]  wa,
  output logic [31:0] wd,
  output logic [14:0] ir_wb,
  output logic        opcode_ld_ldr_wb,
  output logic [31:0] wb_bypass,
  output logic        wb_stall,
  output logic        ld_err,
  output logic [31:0] retire_cnt,
  output logic [31:0] ld_wait_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IR_W   = 15;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WRITE   = 2'd1,
    S_WAIT_LD = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic [IR_W-1:0]     r_ir;
  logic                r_wr_en;
  logic                r_is_load;
  logic                r_ld_err;

  logic                w_accept;
  logic                w_ld_stray;
  logic [REG_W-1:0]    w_rc;
  logic                w_in_write;

  assign w_accept   = mem_valid && mem_ready;
  // Load data is only expected while a load waits or is being accepted.
  assign w_ld_stray = ld_valid && (r_state != S_WAIT_LD) && !(w_accept && mem_is_load);
  assign w_rc       = r_ir[14:10];
  assign w_in_write = (r_state == S_WRITE);

  // State machine and instruction/data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_data    <= '0;
      r_ir      <= '0;
      r_wr_en   <= 1'b0;
      r_is_load <= 1'b0;
      r_ld_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ir      <= mem_ir;
        r_wr_en   <= mem_wr_en;
        r_is_load <= mem_is_load;
        if (!mem_is_load) begin
          r_data  <= mem_result;
          r_state <= S_WRITE;
        end else if (ld_valid) begin
          r_data  <= ld_data;
          r_state <= S_WRITE;
        end else begin
          r_state <= S_WAIT_LD;
        end
      end else begin
        case (r_state)
          S_WAIT_LD: begin
            if (ld_valid) begin
              r_data  <= ld_data;
              r_state <= S_WRITE;
            end
          end
          S_WRITE: r_state <= S_EMPTY;
          default: r_state <= S_EMPTY;
        endcase
      end
      if (w_ld_stray) begin
        r_ld_err <= 1'b1;
      end
    end
  end

  // Outputs decode the registered state only (no input-to-output paths).
  assign mem_ready        = (r_state != S_WAIT_LD);
  assign we               = w_in_write && r_wr_en && (w_rc != 5'd31);
  assign wa               = {1'b0, w_rc};
  assign wd               = w_in_write ? r_data : '0;
  assign wb_bypass        = wd;
  // Rc = 31 in the empty state so hazard logic never matches a live register.
  assign ir_wb            = (r_state == S_EMPTY) ? 15'h7FFF : r_ir;
  assign opcode_ld_ldr_wb = (r_state != S_EMPTY) && r_is_load;
  assign wb_stall         = (r_state == S_WAIT_LD);
  assign ld_err           = r_ld_err;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_ld_wait_cnt;

  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt  <= '0;
      r_ld_wait_cnt <= '0;
    end else begin
      if (r_state == S_WRITE) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (r_state == S_WAIT_LD) begin
        r_ld_wait_cnt <= r_ld_wait_cnt + 32'd1;
      end
    end
  end

  assign retire_cnt  = r_retire_cnt;
  assign ld_wait_cnt = r_ld_wait_cnt;
`else
  assign retire_cnt  = '0;
  assign ld_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_wb_stage.sv
// Directed testbench for reg_wb_stage.
module tb_reg_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [14:0] mem_ir;
  logic        mem_wr_en;
  logic        mem_is_load;
  logic [31:0] mem_result;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [14:0] ir_wb;
  logic        opcode_ld_ldr_wb;
  logic [31:0] wb_bypass;
  logic        wb_stall;
  logic        ld_err;
  logic [31:0] retire_cnt;
  logic [31:0] ld_wait_cnt;

  int checks   = 0;
  int failures = 0;

  reg_wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_ir           (mem_ir),
    .mem_wr_en        (mem_wr_en),
    .mem_is_load      (mem_is_load),
    .mem_result       (mem_result),
    .ld_valid         (ld_valid),
    .ld_data          (ld_data),
    .we               (we),
    .wa               (wa),
    .wd               (wd),
    .ir_wb            (ir_wb),
    .opcode_ld_ldr_wb (opcode_ld_ldr_wb),
    .wb_bypass        (wb_bypass),
    .wb_stall         (wb_stall),
    .ld_err           (ld_err),
    .retire_cnt       (retire_cnt),
    .ld_wait_cnt      (ld_wait_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid   = 1'b0;
    mem_ir      = '0;
    mem_wr_en   = 1'b0;
    mem_is_load = 1'b0;
    mem_result  = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
  endtask

  task automatic issue(input logic [4:0] rc, input logic wr, input logic ld, input logic [31:0] res);
    mem_valid   = 1'b1;
    mem_ir      = {rc, 5'd7, 5'd9};
    mem_wr_en   = wr;
    mem_is_load = ld;
    mem_result  = res;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", mem_ready); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", we); end
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", wb_stall); end
    checks++; if (ir_wb !== 15'h7FFF) begin failures++; $display("FAIL rst_ir_wb got=%h exp=7fff", ir_wb); end
    checks++; if (wd !== 32'h0) begin failures++; $display("FAIL rst_wd got=%h exp=0", wd); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL rst_ld_err got=%0b exp=0", ld_err); end
    checks++; if (retire_cnt !== 32'h0 || ld_wait_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%h/%h exp=0/0", retire_cnt, ld_wait_cnt); end
  endtask

  task automatic test_add();
    do_reset();
    issue(5'd3, 1'b1, 1'b0, 32'h1234);
    step();
    idle_inputs();
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL add_we got=%0b exp=1", we); end
    checks++; if (wa !== 6'd3) begin failures++; $display("FAIL add_wa got=%0d exp=3", wa); end
    checks++; if (wd !== 32'h1234) begin failures++; $display("FAIL add_wd got=%h exp=1234", wd); end
    checks++; if (wb_bypass !== 32'h1234) begin failures++; $display("FAIL add_bypass got=%h exp=1234", wb_bypass); end
    checks++; if (ir_wb !== 15'h0CE9) begin failures++; $display("FAIL add_ir_wb got=%h exp=0ce9", ir_wb); end
    checks++; if (opcode_ld_ldr_wb !== 1'b0) begin failures++; $display("FAIL add_isld got=%0b exp=0", opcode_ld_ldr_wb); end
    step();
    checks++; if (we !== 1'b0 || wd !== 32'h0 || wb_bypass !== 32'h0) begin failures++; $display("FAIL add_empty got=we%0b wd%h bp%h exp=0/0/0", we, wd, wb_bypass); end
    checks++; if (ir_wb !== 15'h7FFF) begin failures++; $display("FAIL add_empty_ir got=%h exp=7fff", ir_wb); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retire_cnt !== 32'd1) begin failures++; $display("FAIL add_retire_cnt got=%0d exp=1", retire_cnt); end
`else
    checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL add_retire_cnt got=%0d exp=0", retire_cnt); end
`endif
  endtask

  task automatic test_load_wait();
    do_reset();
    issue(5'd5, 1'b1, 1'b1, 32'hDEAD);
    step();
    // Another instruction is offered while the load waits; it must not be taken.
    issue(5'd6, 1'b1, 1'b0, 32'h5555);
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_stall !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL ld_stall_c%0d got=stall%0b rdy%0b exp=1/0", i, wb_stall, mem_ready); end
      checks++; if (we !== 1'b0 || opcode_ld_ldr_wb !== 1'b1) begin failures++; $display("FAIL ld_hold_c%0d got=we%0b ld%0b exp=0/1", i, we, opcode_ld_ldr_wb); end
      if (i == 2) begin
        ld_valid = 1'b1;
        ld_data  = 32'hCAFE;
      end
      step();
    end
    idle_inputs();
    checks++; if (we !== 1'b1 || wa !== 6'd5) begin failures++; $display("FAIL ld_write got=we%0b wa%0d exp=1/5", we, wa); end
    checks++; if (wd !== 32'hCAFE || wb_bypass !== 32'hCAFE) begin failures++; $display("FAIL ld_wd got=%h/%h exp=cafe", wd, wb_bypass); end
    checks++; if (opcode_ld_ldr_wb !== 1'b1 || wb_stall !== 1'b0) begin failures++; $display("FAIL ld_flags got=ld%0b st%0b exp=1/0", opcode_ld_ldr_wb, wb_stall); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL ld_err got=%0b exp=0", ld_err); end
`ifdef WB_PERF_CNT_EN
    checks++; if (ld_wait_cnt !== 32'd3) begin failures++; $display("FAIL ld_wait_cnt got=%0d exp=3", ld_wait_cnt); end
`else
    checks++; if (ld_wait_cnt !== 32'd0) begin failures++; $display("FAIL ld_wait_cnt got=%0d exp=0", ld_wait_cnt); end
`endif
    step();
    checks++; if (we !== 1'b0 || ir_wb !== 15'h7FFF) begin failures++; $display("FAIL ld_drain got=we%0b ir%h exp=0/7fff", we, ir_wb); end
  endtask

  task automatic test_load_same_cycle();
    do_reset();
    issue(5'd9, 1'b1, 1'b1, 32'h1111);
    ld_valid = 1'b1;
    ld_data  = 32'hBEEF0001;
    step();
    idle_inputs();
    checks++; if (we !== 1'b1 || wa !== 6'd9 || wd !== 32'hBEEF0001) begin failures++; $display("FAIL ldq got=we%0b wa%0d wd%h exp=1/9/beef0001", we, wa, wd); end
    checks++; if (ld_err !== 1'b0 || wb_stall !== 1'b0) begin failures++; $display("FAIL ldq_flags got=err%0b st%0b exp=0/0", ld_err, wb_stall); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rcs  [3];
    logic [31:0] vals [3];
    logic        wes  [3];
    rcs  = '{5'd1, 5'd2, 5'd31};
    vals = '{32'hA1, 32'hB2, 32'hC3};
    wes  = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(rcs[i], 1'b1, 1'b0, vals[i]);
      step();
      checks++; if (we !== wes[i] || wa !== {1'b0, rcs[i]} || wd !== vals[i]) begin failures++; $display("FAIL b2b_%0d got=we%0b wa%0d wd%h exp=%0b/%0d/%h", i, we, wa, wd, wes[i], rcs[i], vals[i]); end
      checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0b exp=1", i, mem_ready); end
    end
    // Non-load followed directly by a waiting load, then an instruction with wr_en low.
    issue(5'd4, 1'b1, 1'b1, 32'h0);
    step();
    checks++; if (wb_stall !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL b2b_ld got=st%0b we%0b exp=1/0", wb_stall, we); end
    idle_inputs();
    ld_valid = 1'b1;
    ld_data  = 32'h77;
    step();
    issue(5'd8, 1'b0, 1'b0, 32'h99);
    ld_valid = 1'b0;
    checks++; if (we !== 1'b1 || wa !== 6'd4 || wd !== 32'h77) begin failures++; $display("FAIL b2b_ldw got=we%0b wa%0d wd%h exp=1/4/77", we, wa, wd); end
    step();
    idle_inputs();
    checks++; if (we !== 1'b0 || wd !== 32'h99 || wa !== 6'd8) begin failures++; $display("FAIL b2b_nowr got=we%0b wa%0d wd%h exp=0/8/99", we, wa, wd); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retire_cnt !== 32'd4 || ld_wait_cnt !== 32'd1) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=4/1", retire_cnt, ld_wait_cnt); end
`else
    checks++; if (retire_cnt !== 32'd0 || ld_wait_cnt !== 32'd0) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=0/0", retire_cnt, ld_wait_cnt); end
`endif
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    issue(5'd12, 1'b1, 1'b1, 32'h0);
    step();
    idle_inputs();
    checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL rw_stall got=%0b exp=1", wb_stall); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wb_stall !== 1'b0 || mem_ready !== 1'b1 || ir_wb !== 15'h7FFF) begin failures++; $display("FAIL rw_empty got=st%0b rdy%0b ir%h exp=0/1/7fff", wb_stall, mem_ready, ir_wb); end
    ld_valid = 1'b1;
    ld_data  = 32'h1234_5678;
    step();
    ld_valid = 1'b0;
    checks++; if (we !== 1'b0 || wd !== 32'h0 || wb_stall !== 1'b0) begin failures++; $display("FAIL rw_drop got=we%0b wd%h st%0b exp=0/0/0", we, wd, wb_stall); end
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL rw_ld_err got=%0b exp=1", ld_err); end
    step();
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL rw_ld_err_sticky got=%0b exp=1", ld_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL rw_ld_err_clr got=%0b exp=0", ld_err); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
`ifdef WB_PERF_CNT_EN
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    issue(5'd2, 1'b1, 1'b0, 32'h1);
    step();
    idle_inputs();
    checks++; if (retire_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffffffff", retire_cnt); end
    step();
    checks++; if (retire_cnt !== 32'h0) begin failures++; $display("FAIL wrap_post got=%h exp=0", retire_cnt); end
`else
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 1'b1, 1'b0, 32'(i));
      step();
    end
    idle_inputs();
    step();
    checks++; if (retire_cnt !== 32'h0) begin failures++; $display("FAIL wrap_tied got=%h exp=0", retire_cnt); end
    checks++; if (ld_wait_cnt !== 32'h0) begin failures++; $display("FAIL wrap_tied_ld got=%h exp=0", ld_wait_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_load_wait();
    test_load_same_cycle();
    test_back_to_back();
    test_reset_in_wait();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_stage.md
REG_WB_STAGE -- requirements
Module: reg_wb_stage

Interface
REQ-001 The module SHALL have no parameters; it has one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 mem_valid  in  1  memory-access stage presents an instruction.
REQ-005 mem_ready  out  1  stage accepts the instruction this cycle.
REQ-006 mem_ir  in  15  instruction field slice; Rc = [14:10], Ra = [9:5], Rb = [4:0].
REQ-007 mem_wr_en  in  1  instruction writes Rc.
REQ-008 mem_is_load  in  1  opcode is LD or LDR.
REQ-009 mem_result  in  32  ALU result or PC+4 for non-load instructions.
REQ-010 ld_valid  in  1  load data returned from data memory.
REQ-011 ld_data  in  32  returned load data.
REQ-012 we / wa / wd  out  1 / 6 / 32  register-file write port; wa[5] always 0.
REQ-013 ir_wb  out  15  instruction held in write-back.
REQ-014 opcode_ld_ldr_wb  out  1  held instruction is a load.
REQ-015 wb_bypass  out  32  bypass value equal to wd.
REQ-016 wb_stall  out  1  write-back is waiting on load data.
REQ-017 ld_err  out  1  sticky unexpected-ld_valid flag.
REQ-018 retire_cnt / ld_wait_cnt  out  32 / 32  performance counters.

Function
REQ-019 The FSM SHALL have three states: EMPTY, WRITE, WAIT_LD.
REQ-020 mem_ready SHALL be 1 in EMPTY and WRITE, and 0 in WAIT_LD; acceptance = mem_valid && mem_ready.
REQ-021 On acceptance with a non-load, the FSM SHALL go to WRITE and latch mem_result, mem_ir and mem_wr_en.
REQ-022 On acceptance of a load with ld_valid in the same cycle, the FSM SHALL go to WRITE with data = ld_data.
REQ-023 On acceptance of a load without ld_valid, the FSM SHALL go to WAIT_LD.
REQ-024 In WAIT_LD with ld_valid, the FSM SHALL latch ld_data and go to WRITE; without ld_valid it SHALL remain in WAIT_LD.
REQ-025 In WRITE without acceptance, the FSM SHALL go to EMPTY; with acceptance, REQ-021 to REQ-023 apply (back-to-back, no bubble).
REQ-026 we SHALL equal (state == WRITE) && latched wr_en && (Rc != 31); R31 writes are discarded.
REQ-027 wa SHALL be {1'b0, Rc} and wd SHALL be the latched data; wd and wb_bypass SHALL be 0 outside WRITE.
REQ-028 ir_wb SHALL be the latched instruction in WRITE/WAIT_LD and 15'h7FFF (Rc = 31, no hazard match) in EMPTY.
REQ-029 opcode_ld_ldr_wb SHALL be 1 whenever the held instruction is a load (WRITE or WAIT_LD).
REQ-030 wb_stall SHALL be (state == WAIT_LD).
REQ-031 ld_valid with no load pending and no load being accepted SHALL set ld_err; the data is ignored.
REQ-032 Latency: a non-load accepted in cycle N SHALL produce we in cycle N+1.

Reset
REQ-033 While rst is high: state = EMPTY, ld_err = 0, counters = 0, latched data/ir/wr_en cleared; this holds mid-WAIT_LD too, and the pending load is dropped.
REQ-034 In the first cycle after reset, outputs SHALL read: mem_ready = 1, we = 0, wb_stall = 0, ir_wb = 15'h7FFF.

Configuration
REQ-035 Macro WB_PERF_CNT_EN, when defined: retire_cnt SHALL increment on each WRITE cycle and ld_wait_cnt on each WAIT_LD cycle, both wrapping 0xFFFFFFFF -> 0.
REQ-036 Without WB_PERF_CNT_EN, both counters SHALL be tied to 0 and the ports SHALL remain present.

Verification
REQ-037 ADD to R3 with result 0x1234 accepted in cycle 1 -> cycle 2: we = 1, wa = 3, wd = wb_bypass = 0x1234.
REQ-038 LD to R5 with ld_valid delayed 3 cycles (data 0xCAFE) -> wb_stall = 1 and mem_ready = 0 for 3 cycles, then we = 1, wa = 5, wd = 0xCAFE; ld_wait_cnt = 3 when the macro is defined.
REQ-039 Back-to-back non-loads to R1, R2 and R31 -> we = 1, 1, 0 on consecutive cycles, with no bubbles.
REQ-040 rst asserted during WAIT_LD, then ld_valid -> state EMPTY, we = 0, ld_err = 1.
REQ-041 Preset retire_cnt to 0xFFFFFFFF via 2^32-1 retirements or force, then one more retirement -> retire_cnt = 0; without the macro, retire_cnt = 0 throughout.
